rename_map_stage: RTL and testbench
===================================

Name: rename_map_stage

Overview:
- Single-wide register-rename stage placed between decode and dispatch.
- Maps architectural source and destination registers to physical registers using a speculative map table (SRAT).
- Pops new destination pregs from free_preg_queue and returns freed pregs to it on retire or squash.
- Keeps a retirement map table (RRAT) and copies it into the SRAT on flush.

Parameters:
NUM_AREGS, 32, architectural register count
AREG_W, 5, architectural register index width
PREG_W, 7, physical register index width (128 pregs)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decoded uop valid
in_ready  output  1  stage can accept uop
in_rs1  input  AREG_W  source 1 areg
in_rs2  input  AREG_W  source 2 areg
in_rd  input  AREG_W  destination areg
in_rd_wen  input  1  uop writes rd
out_valid  output  1  renamed uop valid
out_ready  input  1  dispatch accepts uop
out_prs1  output  PREG_W  renamed source 1
out_prs2  output  PREG_W  renamed source 2
out_prd  output  PREG_W  newly allocated preg
out_old_prd  output  PREG_W  previous mapping of rd (for ROB)
out_rd_wen  output  1  effective destination write
fl_r_en  output  1  pop free list
fl_preg  input  PREG_W  free-list head (valid when !fl_empty)
fl_empty  input  1  free list empty
fl_w_en  output  1  push to free list
fl_preg_in  output  PREG_W  preg being freed
fl_full  input  1  free list full
ret_valid  input  1  retire/squash request
ret_ready  output  1  request accepted (= !fl_full)
ret_squash  input  1  1: squash free, 0: retire
ret_rd  input  AREG_W  areg of retiring/squashed uop
ret_prd  input  PREG_W  preg allocated to that uop
ret_old_prd  input  PREG_W  previous mapping
flush  input  1  pipeline flush

Behaviour:
- Reset (async, rst_n=0):
  - SRAT[i] and RRAT[i] = i for all i.
  - out_valid=0, all out_* = 0.
  - in_ready=0 and fl_r_en=0 while rst_n is low.
- Allocation rule: alloc = in_rd_wen && in_rd!=0. x0 is never renamed; SRAT[0] stays 0.
- in_ready = !flush && (!out_valid || out_ready) && (!alloc || !fl_empty). This is combinational.
- Accept when in_valid && in_ready. On the same edge:
  - out_valid<=1.
  - out_prs1<=SRAT[in_rs1], out_prs2<=SRAT[in_rs2].
  - If alloc: out_prd<=fl_preg, out_old_prd<=SRAT[in_rd], SRAT[in_rd]<=fl_preg, out_rd_wen<=1.
  - If not alloc: out_prd=out_old_prd=0, out_rd_wen=0.
- fl_r_en = accept && alloc. It pulses exactly one cycle per allocation. The free list presents its head combinationally and pops on the edge.
- Sources are read before the same-edge SRAT write. Back-to-back dependent uops see the updated SRAT because they are accepted on a later edge.
- Latency is 1 cycle from accept to out_valid.
- Output register:
  - Holds all fields stable while out_valid && !out_ready.
  - Clears out_valid when out_ready && !accept.
- Retire (ret_valid && ret_ready && !ret_squash && ret_rd!=0): RRAT[ret_rd]<=ret_prd, fl_w_en=1, fl_preg_in=ret_old_prd.
- Squash (ret_valid && ret_ready && ret_squash && ret_rd!=0): fl_w_en=1, fl_preg_in=ret_prd. RRAT is unchanged.
- ret_rd==0: no free and no RRAT write. ret_ready still asserts (request is consumed).
- fl_w_en and fl_preg_in are combinational from the ret_* inputs.
- Flush:
  - SRAT<=RRAT on the edge, with a same-cycle retire write bypassed into the copy.
  - out_valid<=0.
  - No accept and no fl_r_en in the flush cycle.
  - The ret_* port stays active during flush so the ROB squash walk can return pregs.
- Simultaneous fl_r_en and fl_w_en are legal.
- Reset asserted mid-operation discards the in-flight uop and restores the identity maps.

Test Plan:
1. Reset: out_valid=0 and in_ready=0 during reset. After release, with fl_preg=32, rename rd=1 rs1=2 rs2=0 -> next cycle out_prs1=2, out_prs2=0, out_prd=32, out_old_prd=1, out_rd_wen=1; fl_r_en high for exactly 1 cycle.
2. Dependency chain: rename rd=1 (preg 32), then rd=3 rs1=1 with fl_preg=33 -> out_prs1=32, out_prd=33, out_old_prd=3.
3. No-alloc cases (rd=0 or in_rd_wen=0), with fl_empty=1 -> uop accepted, fl_r_en=0, out_prd=0, out_rd_wen=0.
4. fl_empty=1 with an allocating uop -> in_ready=0 and output holds; deassert fl_empty with fl_preg=40 -> accept next edge, out_prd=40. Separately, out_ready=0 for 3 cycles -> out_* stable and in_ready=0.
5. Retire ret_rd=1 ret_prd=32 ret_old_prd=1 -> fl_w_en=1, fl_preg_in=1. Then rename rd=1 -> 33, then flush. A following uop with rs1=1 gives out_prs1=32. Squash ret_prd=33 -> fl_preg_in=33.
6. Retire ret_rd=5 ret_prd=50 in the same cycle as flush -> a following uop with rs1=5 gives out_prs1=50. fl_full=1 -> ret_ready=0 and fl_w_en=0.

Source files
------------

// File: rtl/rename_map_stage.sv
// Single-wide register rename stage: speculative/retirement map tables,
// free-list pop on allocation, free-list push on retire or squash.
module rename_map_stage #(
  parameter int NUM_AREGS = 32,
  parameter int AREG_W    = 5,
  parameter int PREG_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AREG_W-1:0] in_rs1,
  input  logic [AREG_W-1:0] in_rs2,
  input  logic [AREG_W-1:0] in_rd,
  input  logic              in_rd_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_rd_wen,
  output logic              fl_r_en,
  input  logic [PREG_W-1:0] fl_preg,
  input  logic              fl_empty,
  output logic              fl_w_en,
  output logic [PREG_W-1:0] fl_preg_in,
  input  logic              fl_full,
  input  logic              ret_valid,
  output logic              ret_ready,
  input  logic              ret_squash,
  input  logic [AREG_W-1:0] ret_rd,
  input  logic [PREG_W-1:0] ret_prd,
  input  logic [PREG_W-1:0] ret_old_prd,
  input  logic              flush
);

  logic [PREG_W-1:0] srat [NUM_AREGS];
  logic [PREG_W-1:0] rrat [NUM_AREGS];

  logic alloc_p0;
  logic accept_p0;
  logic ret_fire;
  logic retire_wr;

  logic              vld_p1;
  logic [PREG_W-1:0] prs1_p1;
  logic [PREG_W-1:0] prs2_p1;
  logic [PREG_W-1:0] prd_p1;
  logic [PREG_W-1:0] old_prd_p1;
  logic              rd_wen_p1;

  // x0 is hardwired, so it never consumes a physical register.
  assign alloc_p0  = in_rd_wen && (in_rd != '0);
  assign in_ready  = rst_n && !flush && (!vld_p1 || out_ready) && (!alloc_p0 || !fl_empty);
  assign accept_p0 = in_valid && in_ready;
  assign fl_r_en   = accept_p0 && alloc_p0;

  // A request targeting x0 is consumed but frees nothing.
  assign ret_ready  = !fl_full;
  assign ret_fire   = ret_valid && ret_ready && (ret_rd != '0);
  assign retire_wr  = ret_fire && !ret_squash;
  assign fl_w_en    = ret_fire;
  assign fl_preg_in = !ret_fire ? '0 : (ret_squash ? ret_prd : ret_old_prd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        srat[i] <= PREG_W'(i);
        rrat[i] <= PREG_W'(i);
      end
    end else begin
      if (retire_wr) rrat[ret_rd] <= ret_prd;
      // Flush restores committed state, including a retire landing this same edge.
      if (flush) begin
        for (int i = 0; i < NUM_AREGS; i++)
          srat[i] <= (retire_wr && (ret_rd == AREG_W'(i))) ? ret_prd : rrat[i];
      end else if (fl_r_en) begin
        srat[in_rd] <= fl_preg;
      end
    end
  end

  // ---- p0 -> p1: renamed uop output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      prs1_p1    <= '0;
      prs2_p1    <= '0;
      prd_p1     <= '0;
      old_prd_p1 <= '0;
      rd_wen_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      prs1_p1    <= srat[in_rs1];
      prs2_p1    <= srat[in_rs2];
      prd_p1     <= alloc_p0 ? fl_preg : '0;
      old_prd_p1 <= alloc_p0 ? srat[in_rd] : '0;
      rd_wen_p1  <= alloc_p0;
    end else if (flush || out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_prs1    = prs1_p1;
  assign out_prs2    = prs2_p1;
  assign out_prd     = prd_p1;
  assign out_old_prd = old_prd_p1;
  assign out_rd_wen  = rd_wen_p1;

endmodule

// File: tb/tb_rename_map_stage.sv
// Directed bench for rename_map_stage: rename, dependency, stalls,
// retire/squash frees, flush recovery and mid-run reset.
module tb_rename_map_stage;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_rd_wen;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       out_valid, out_ready, out_rd_wen;
  logic [6:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic       fl_r_en, fl_empty, fl_w_en, fl_full;
  logic [6:0] fl_preg, fl_preg_in;
  logic       ret_valid, ret_ready, ret_squash, flush;
  logic [4:0] ret_rd;
  logic [6:0] ret_prd, ret_old_prd;

  int vecs = 0;
  int errs = 0;

  rename_map_stage #(.NUM_AREGS(32), .AREG_W(5), .PREG_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
    .fl_r_en(fl_r_en), .fl_preg(fl_preg), .fl_empty(fl_empty),
    .fl_w_en(fl_w_en), .fl_preg_in(fl_preg_in), .fl_full(fl_full),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_squash(ret_squash),
    .ret_rd(ret_rd), .ret_prd(ret_prd), .ret_old_prd(ret_old_prd),
    .flush(flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rd_wen = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    ret_valid = 0; ret_squash = 0; ret_rd = 0; ret_prd = 0; ret_old_prd = 0;
    flush = 0; fl_full = 0;
  endtask

  task automatic uop(input logic [4:0] rd, input logic wen, input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid = 1; in_rd = rd; in_rd_wen = wen; in_rs1 = rs1; in_rs2 = rs2;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; out_ready = 1; fl_empty = 0; fl_preg = 7'd32;
    uop(5'd1, 1, 5'd2, 5'd0);
    tick(); tick();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    vecs++; if (fl_r_en !== 1'b0) begin errs++; $display("FAIL rst_fl_r_en got %0b exp 0", fl_r_en); end
    vecs++; if (out_prd !== 7'd0) begin errs++; $display("FAIL rst_out_prd got %0d exp 0", out_prd); end
    rst_n = 1;
    #1;
    vecs++; if (fl_r_en !== 1'b1) begin errs++; $display("FAIL basic_fl_r_en got %0b exp 1", fl_r_en); end
    tick();
    in_valid = 0;
    #1;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_out_valid got %0b exp 1", out_valid); end
    vecs++; if (out_prs1 !== 7'd2) begin errs++; $display("FAIL basic_prs1 got %0d exp 2", out_prs1); end
    vecs++; if (out_prs2 !== 7'd0) begin errs++; $display("FAIL basic_prs2 got %0d exp 0", out_prs2); end
    vecs++; if (out_prd !== 7'd32) begin errs++; $display("FAIL basic_prd got %0d exp 32", out_prd); end
    vecs++; if (out_old_prd !== 7'd1) begin errs++; $display("FAIL basic_old_prd got %0d exp 1", out_old_prd); end
    vecs++; if (out_rd_wen !== 1'b1) begin errs++; $display("FAIL basic_rd_wen got %0b exp 1", out_rd_wen); end
    vecs++; if (fl_r_en !== 1'b0) begin errs++; $display("FAIL basic_fl_r_en_pulse got %0b exp 0", fl_r_en); end
  endtask

  // SRAT now: x1->32
  task automatic test_dependency();
    fl_preg = 7'd33;
    uop(5'd3, 1, 5'd1, 5'd3);
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL dep_in_ready got %0b exp 1", in_ready); end
    tick();
    in_valid = 0;
    vecs++; if (out_prs1 !== 7'd32) begin errs++; $display("FAIL dep_prs1 got %0d exp 32", out_prs1); end
    vecs++; if (out_prs2 !== 7'd3) begin errs++; $display("FAIL dep_prs2 got %0d exp 3", out_prs2); end
    vecs++; if (out_prd !== 7'd33) begin errs++; $display("FAIL dep_prd got %0d exp 33", out_prd); end
    vecs++; if (out_old_prd !== 7'd3) begin errs++; $display("FAIL dep_old_prd got %0d exp 3", out_old_prd); end
  endtask

  // SRAT now: x1->32, x3->33
  task automatic test_no_alloc();
    fl_empty = 1;
    uop(5'd0, 1, 5'd3, 5'd1);
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL noalloc_x0_in_ready got %0b exp 1", in_ready); end
    vecs++; if (fl_r_en !== 1'b0) begin errs++; $display("FAIL noalloc_x0_fl_r_en got %0b exp 0", fl_r_en); end
    tick();
    vecs++; if (out_prs1 !== 7'd33 || out_prs2 !== 7'd32) begin errs++; $display("FAIL noalloc_x0_srcs got %0d/%0d exp 33/32", out_prs1, out_prs2); end
    vecs++; if (out_prd !== 7'd0 || out_old_prd !== 7'd0 || out_rd_wen !== 1'b0) begin errs++; $display("FAIL noalloc_x0_dst got %0d/%0d/%0b exp 0/0/0", out_prd, out_old_prd, out_rd_wen); end
    uop(5'd5, 0, 5'd5, 5'd0);
    #1;
    vecs++; if (fl_r_en !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL noalloc_wen0_hs got r_en=%0b rdy=%0b exp 0/1", fl_r_en, in_ready); end
    tick();
    in_valid = 0;
    vecs++; if (out_prs1 !== 7'd5 || out_prd !== 7'd0 || out_rd_wen !== 1'b0 || out_valid !== 1'b1) begin errs++; $display("FAIL noalloc_wen0_out got prs1=%0d prd=%0d wen=%0b vld=%0b exp 5/0/0/1", out_prs1, out_prd, out_rd_wen, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    uop(5'd4, 1, 5'd0, 5'd0);
    #1;
    vecs++; if (in_ready !== 1'b0 || fl_r_en !== 1'b0) begin errs++; $display("FAIL empty_block got rdy=%0b r_en=%0b exp 0/0", in_ready, fl_r_en); end
    tick();
    vecs++; if (out_valid !== 1'b1 || out_prs1 !== 7'd5) begin errs++; $display("FAIL empty_hold got vld=%0b prs1=%0d exp 1/5", out_valid, out_prs1); end
    out_ready = 1; fl_empty = 0; fl_preg = 7'd40;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL empty_release got %0b exp 1", in_ready); end
    tick();
    vecs++; if (out_prd !== 7'd40 || out_old_prd !== 7'd4 || out_prs1 !== 7'd0) begin errs++; $display("FAIL empty_accept got prd=%0d old=%0d prs1=%0d exp 40/4/0", out_prd, out_old_prd, out_prs1); end
    out_ready = 0; fl_preg = 7'd41;
    uop(5'd6, 1, 5'd1, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (in_ready !== 1'b0 || fl_r_en !== 1'b0) begin errs++; $display("FAIL stall_rdy cyc %0d got rdy=%0b r_en=%0b exp 0/0", i, in_ready, fl_r_en); end
      tick();
      vecs++; if (out_valid !== 1'b1 || out_prd !== 7'd40 || out_old_prd !== 7'd4) begin errs++; $display("FAIL stall_hold cyc %0d got vld=%0b prd=%0d old=%0d exp 1/40/4", i, out_valid, out_prd, out_old_prd); end
    end
    in_valid = 0; out_ready = 1;
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL drain got %0b exp 0", out_valid); end
  endtask

  // SRAT: x1->32 x3->33 x4->40; RRAT identity
  task automatic test_retire_flush();
    ret_valid = 1; ret_squash = 0; ret_rd = 5'd1; ret_prd = 7'd32; ret_old_prd = 7'd1;
    fl_preg = 7'd33;
    uop(5'd1, 1, 5'd0, 5'd0);
    #1;
    vecs++; if (ret_ready !== 1'b1 || fl_w_en !== 1'b1 || fl_preg_in !== 7'd1) begin errs++; $display("FAIL retire_free got rdy=%0b w_en=%0b preg=%0d exp 1/1/1", ret_ready, fl_w_en, fl_preg_in); end
    vecs++; if (fl_r_en !== 1'b1) begin errs++; $display("FAIL retire_concurrent_pop got %0b exp 1", fl_r_en); end
    tick();
    idle();
    vecs++; if (out_prd !== 7'd33 || out_old_prd !== 7'd32) begin errs++; $display("FAIL retire_rename got prd=%0d old=%0d exp 33/32", out_prd, out_old_prd); end
    flush = 1; out_ready = 0; fl_preg = 7'd44;
    uop(5'd2, 1, 5'd0, 5'd0);
    #1;
    vecs++; if (in_ready !== 1'b0 || fl_r_en !== 1'b0) begin errs++; $display("FAIL flush_block got rdy=%0b r_en=%0b exp 0/0", in_ready, fl_r_en); end
    tick();
    idle(); out_ready = 1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_clear got %0b exp 0", out_valid); end
    uop(5'd0, 0, 5'd1, 5'd3);
    tick();
    idle();
    vecs++; if (out_prs1 !== 7'd32 || out_prs2 !== 7'd3) begin errs++; $display("FAIL flush_restore got %0d/%0d exp 32/3", out_prs1, out_prs2); end
    ret_valid = 1; ret_squash = 1; ret_rd = 5'd1; ret_prd = 7'd33; ret_old_prd = 7'd32;
    #1;
    vecs++; if (fl_w_en !== 1'b1 || fl_preg_in !== 7'd33) begin errs++; $display("FAIL squash_free got w_en=%0b preg=%0d exp 1/33", fl_w_en, fl_preg_in); end
    tick();
    ret_rd = 5'd0; ret_squash = 0; ret_prd = 7'd9;
    #1;
    vecs++; if (fl_w_en !== 1'b0 || ret_ready !== 1'b1) begin errs++; $display("FAIL ret_x0 got w_en=%0b rdy=%0b exp 0/1", fl_w_en, ret_ready); end
    tick();
    idle();
  endtask

  // RRAT: x1->32, rest identity; SRAT equal to RRAT
  task automatic test_flush_bypass();
    ret_valid = 1; ret_squash = 0; ret_rd = 5'd5; ret_prd = 7'd50; ret_old_prd = 7'd5;
    flush = 1;
    tick();
    idle();
    uop(5'd0, 0, 5'd5, 5'd4);
    tick();
    idle();
    vecs++; if (out_prs1 !== 7'd50 || out_prs2 !== 7'd4) begin errs++; $display("FAIL bypass got %0d/%0d exp 50/4", out_prs1, out_prs2); end
    fl_full = 1; ret_valid = 1; ret_rd = 5'd6; ret_prd = 7'd60; ret_old_prd = 7'd6;
    #1;
    vecs++; if (ret_ready !== 1'b0 || fl_w_en !== 1'b0) begin errs++; $display("FAIL full_block got rdy=%0b w_en=%0b exp 0/0", ret_ready, fl_w_en); end
    tick();
    idle();
    flush = 1;
    tick();
    idle();
    uop(5'd0, 0, 5'd6, 5'd1);
    tick();
    idle();
    vecs++; if (out_prs1 !== 7'd6 || out_prs2 !== 7'd32) begin errs++; $display("FAIL full_no_rrat got %0d/%0d exp 6/32", out_prs1, out_prs2); end
  endtask

  task automatic test_reset_mid();
    fl_preg = 7'd70;
    uop(5'd7, 1, 5'd0, 5'd0);
    tick();
    idle();
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_prd !== 7'd0) begin errs++; $display("FAIL midrst got vld=%0b rdy=%0b prd=%0d exp 0/0/0", out_valid, in_ready, out_prd); end
    tick();
    rst_n = 1; out_ready = 1;
    uop(5'd0, 0, 5'd1, 5'd7);
    tick();
    idle();
    vecs++; if (out_prs1 !== 7'd1 || out_prs2 !== 7'd7) begin errs++; $display("FAIL midrst_identity got %0d/%0d exp 1/7", out_prs1, out_prs2); end
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_no_alloc();
    test_backpressure();
    test_retire_flush();
    test_flush_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
